// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe
// Pipelined barrel shifter with ROL, ROR, SLL and SRA modes on a WIDTH-bit word.
// Stage k shifts by 2^k when its shift-amount bit is set. There is one register
// stage per shift-amount bit. A valid/ready handshake on each side lets bubbles collapse.

module barrel_shifter_pipe #(
    parameter int WIDTH   = 8,
    parameter int SHIFT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHIFT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero
);

    localparam int N = SHIFT_W;

    localparam logic [1:0] MODE_ROL = 2'b00;
    localparam logic [1:0] MODE_ROR = 2'b01;
    localparam logic [1:0] MODE_SLL = 2'b10;

    // w_rdy[k] is the load enable of stage k's register.
    // w_rdy[N] comes from downstream.
    logic [N:0] w_rdy;

    assign w_rdy[N]  = out_ready;
    assign in_ready  = w_rdy[0];

    for (genvar k = 0; k < N; k++) begin : gStage
        localparam int AMT = 1 << k;
        localparam int SW  = SHIFT_W - k;

        logic [WIDTH-1:0]   w_dIn;
        logic [SW-1:0]      w_sIn;
        logic [1:0]         w_mIn;
        logic               w_vIn;
        logic [WIDTH-1:0]   w_shifted;
        logic [2*WIDTH-1:0] w_wide;

        logic               r_valid;
        logic [WIDTH-1:0]   r_data;

        // Only the shift-amount bits still needed travel down the pipe.
        // So bit 0 of w_sIn is always this stage's control bit.
        if (k == 0) begin : gSrc
            assign w_dIn = in_data;
            assign w_sIn = in_shamt;
            assign w_mIn = in_mode;
            assign w_vIn = in_valid;
        end else begin : gSrc
            assign w_dIn = gStage[k-1].r_data;
            assign w_sIn = gStage[k-1].gCarry.r_shamt;
            assign w_mIn = gStage[k-1].gCarry.r_mode;
            assign w_vIn = gStage[k-1].r_valid;
        end

        assign w_rdy[k] = !r_valid || w_rdy[k+1];

        // Apply this stage's fixed 2^k shift in the selected mode, or pass the data through.
        // For SRA, the current MSB is the original sign bit.
        always_comb begin
            w_wide    = '0;
            w_shifted = w_dIn;
            if (w_sIn[0]) begin
                case (w_mIn)
                    MODE_ROL: begin
                        w_wide    = {w_dIn, w_dIn} << AMT;
                        w_shifted = w_wide[2*WIDTH-1:WIDTH];
                    end
                    MODE_ROR: begin
                        w_wide    = {w_dIn, w_dIn} >> AMT;
                        w_shifted = w_wide[WIDTH-1:0];
                    end
                    MODE_SLL: begin
                        w_shifted = w_dIn << AMT;
                    end
                    default: begin
                        w_wide    = {{WIDTH{w_dIn[WIDTH-1]}}, w_dIn} >> AMT;
                        w_shifted = w_wide[WIDTH-1:0];
                    end
                endcase
            end
        end

        // Stage valid/data register. Data is held whenever no new word is loaded.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (w_rdy[k]) begin
                r_valid <= w_vIn;
                if (w_vIn) begin
                    r_data <= w_shifted;
                end
            end
        end

        // The final stage does not register mode or shift amount, because no later stage uses them.
        if (k < N - 1) begin : gCarry
            logic [SW-2:0] r_shamt;
            logic [1:0]    r_mode;

            // Carry the remaining shift-amount bits and the mode alongside the data.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_shamt <= '0;
                    r_mode  <= '0;
                end else if (w_rdy[k] && w_vIn) begin
                    r_shamt <= w_sIn[SW-1:1];
                    r_mode  <= w_mIn;
                end
            end
        end
    end

    assign out_valid = gStage[N-1].r_valid;
    assign out_data  = gStage[N-1].r_data;
    assign out_zero  = out_valid && (out_data == '0);

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe
// Scoreboard bench for barrel_shifter_pipe with WIDTH=8.
// Expected words are queued at accept time and compared at the output.

module tb_barrel_shifter_pipe;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_shamt;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_zero;

    int checkCount  = 0;
    int failCount   = 0;
    int acceptCount = 0;
    int popCount    = 0;
    int stallCount  = 0;
    bit streamDone  = 0;
    bit randomOn    = 0;

    logic [7:0] expQ[$];

    barrel_shifter_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. Each result bit is computed from its source bit index.
    function automatic logic [7:0] modelShift(input logic [7:0] d, input int s, input logic [1:0] m);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            case (m)
                2'b00:   r[i] = d[(i - s + 8) % 8];
                2'b01:   r[i] = d[(i + s) % 8];
                2'b10:   r[i] = (i >= s) ? d[i - s] : 1'b0;
                default: r[i] = (i + s < 8) ? d[i + s] : d[7];
            endcase
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Offer one word. The expected result is queued on the negedge before the accepting edge.
    task automatic applyStimulus(input logic [7:0] data, input logic [2:0] shamt,
                                 input logic [1:0] mode, input logic [7:0] expected);
        bit accepted = 0;
        in_valid = 1'b1;
        in_data  = data;
        in_shamt = shamt;
        in_mode  = mode;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                accepted = 1;
                expQ.push_back(expected);
                acceptCount++;
                break;
            end
            stallCount++;
            @(posedge clk);
            #1;
        end
        if (accepted) begin
            @(posedge clk);
            #1;
        end else begin
            checkOutput("acceptTimeout", 32'(accepted), 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain", 32'(expQ.size()), 32'd0);
    endtask

    // Output monitor. A stalled word must keep matching the queue head until it is consumed.
    always @(negedge clk) begin
        if (reset) begin
            expQ.delete();
        end else if (out_valid === 1'b1 && expQ.size() != 0) begin
            checkOutput("outData", 32'(out_data), 32'(expQ[0]));
            checkOutput("outZero", 32'(out_zero), 32'(expQ[0] == 8'h00));
            if (out_ready) begin
                void'(expQ.pop_front());
                popCount++;
            end
        end else if (expQ.size() == 0) begin
            checkOutput("noWordValid", 32'(out_valid), 32'd0);
            checkOutput("noWordZero", 32'(out_zero), 32'd0);
        end
    end

    // Global time limit so that the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] dv;
        int         sv;
        logic [1:0] mv;
        int         stallBase;
        int         acceptBase;
        int         popBase;
        int         lat;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = '0;
        out_ready = 1'b0;

        // Reset for two cycles, then check the idle state.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rstOutValid", 32'(out_valid), 32'd0);
        checkOutput("rstOutData", 32'(out_data), 32'h00);
        checkOutput("rstOutZero", 32'(out_zero), 32'd0);
        checkOutput("rstInReady", 32'(in_ready), 32'd1);

        // Mode vectors on 0x96, streamed back to back.
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        stallBase = stallCount;
        applyStimulus(8'h96, 3'd3, 2'b00, 8'hB4);
        applyStimulus(8'h96, 3'd1, 2'b01, 8'h4B);
        applyStimulus(8'h96, 3'd4, 2'b10, 8'h60);
        applyStimulus(8'h96, 3'd2, 2'b11, 8'hE5);
        applyStimulus(8'h96, 3'd7, 2'b11, 8'hFF);
        checkOutput("throughput", 32'(stallCount - stallBase), 32'd0);
        waitDrain();

        // Zero flag and the shamt=0 identity case.
        applyStimulus(8'h80, 3'd1, 2'b10, 8'h00);
        applyStimulus(8'h5A, 3'd0, 2'b01, 8'h5A);
        applyStimulus(8'h81, 3'd7, 2'b10, 8'h80);
        waitDrain();

        // Back-pressure: six words are offered while downstream is blocked.
        out_ready  = 1'b0;
        acceptBase = acceptCount;
        popBase    = popCount;
        streamDone = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [7:0] sdv;
                    sdv = 8'(29 * (i + 1) + 3);
                    applyStimulus(sdv, 3'(i + 1), 2'(i), modelShift(sdv, i + 1, 2'(i)));
                end
                streamDone = 1;
            end
        join_none
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("bpAccepted", 32'(acceptCount - acceptBase), 32'd3);
        checkOutput("bpInReady", 32'(in_ready), 32'd0);
        checkOutput("bpOutValid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && !streamDone; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("bpStreamDone", 32'(streamDone), 32'd1);
        waitDrain();
        checkOutput("bpPopped", 32'(popCount - popBase), 32'd6);
        checkOutput("bpAcceptTotal", 32'(acceptCount - acceptBase), 32'd6);

        // Bubbles: alternate valid and idle cycles while out_ready toggles at random.
        randomOn = 1;
        fork
            begin
                while (randomOn) begin
                    @(posedge clk);
                    #1;
                    if (randomOn) out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 16; i++) begin
            dv = 8'($urandom);
            sv = int'($urandom_range(0, 7));
            mv = 2'($urandom_range(0, 3));
            applyStimulus(dv, 3'(sv), mv, modelShift(dv, sv, mv));
            @(posedge clk);
            #1;
        end
        randomOn = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitDrain();

        // Reset while three words are in flight. A transfer offered during reset must be dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dv = 8'(8'h31 + 8'(i));
            applyStimulus(dv, 3'(i + 2), 2'(i), modelShift(dv, i + 2, 2'(i)));
        end
        @(negedge clk);
        checkOutput("preRstFull", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_shamt = 3'd0;
        in_mode  = 2'b00;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("postRstValid", 32'(out_valid), 32'd0);
        end
        checkOutput("postRstInReady", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(8'h01, 3'd1, 2'b00, 8'h02);
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
            @(posedge clk);
            lat++;
        end
        checkOutput("postRstLatency", 32'(lat), 32'd3);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
